// File: rtl/alu_arbiter_sequencer.sv
// Round-robin arbiter that shares one Paul-ALU between N_REQ requesters and sequences its operand/result words.
// Latency: grant to rsp_valid = 1 + operand words + result words + 1 cycles with back-to-back ALU strobes.
// Backpressure: requesters hold req until granted; the ALU paces the transfer with load/push, and a watchdog aborts stalls.
module alu_arbiter_sequencer #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_opa,
  input  logic [WIDTH*N_REQ-1:0] req_opb,
  input  logic [WIDTH*N_REQ-1:0] req_opc,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_hi,
  output logic [WIDTH-1:0]       rsp_lo,
  output logic                   rsp_err,
  output logic                   alu_begin,
  output logic [1:0]             alu_op_code,
  output logic                   alu_abort,
  output logic [WIDTH-1:0]       alu_inbus,
  input  logic                   alu_load,
  input  logic                   alu_push,
  input  logic [WIDTH-1:0]       alu_outbus,
  input  logic                   alu_end
);

  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_COLLECT,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t state_q, state_d;

  // Transaction context captured at grant time.
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q, opc_q;

  // Progress counters and response accumulators.
  logic [1:0]       idx_q;
  logic [1:0]       rcnt_q;
  logic [WD_W-1:0]  wdog_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // Round-robin scan result.
  logic [SEL_W-1:0] scan_sel;
  logic             scan_hit;

  // Datapath strobes decided by the next-state logic.
  logic do_grant;
  logic idx_inc;
  logic cap_word;
  logic wd_clr;
  logic wd_inc;
  logic ptr_adv;

  logic [WIDTH-1:0] cur_word;
  logic [1:0]       last_word;
  logic [1:0]       last_res;
  logic             wd_expire;
  logic             activity;

  // Word counts depend only on the op: div feeds three words, mul/div return two.
  assign last_word = (op_q == OP_DIV) ? 2'd2 : 2'd1;
  assign last_res  = op_q[1] ? 2'd1 : 2'd0;
  assign wd_expire = (wdog_q >= WD_W'(TIMEOUT - 1));
  assign activity  = alu_load | alu_push;

  assign rsp_hi = hi_q;
  assign rsp_lo = lo_q;

  // Find the first requester at or above the pointer, wrapping around.
  always_comb begin : p_scan
    int j;
    j        = 0;
    scan_hit = 1'b0;
    scan_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (!scan_hit && req[j]) begin
        scan_hit = 1'b1;
        scan_sel = SEL_W'(j);
      end
    end
  end

  // Operand word offered on the bus; mul sends the multiplier (Q) first.
  always_comb begin
    cur_word = '0;
    case (op_q)
      OP_MUL:  cur_word = (idx_q == 2'd0) ? opb_q : opa_q;
      OP_DIV:  cur_word = (idx_q == 2'd0) ? opa_q :
                          (idx_q == 2'd1) ? opb_q : opc_q;
      default: cur_word = (idx_q == 2'd0) ? opa_q : opb_q;
    endcase
  end

  // Next state, ALU/requester outputs and datapath strobes.
  always_comb begin
    state_d     = state_q;
    do_grant    = 1'b0;
    idx_inc     = 1'b0;
    cap_word    = 1'b0;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;
    ptr_adv     = 1'b0;
    grant       = '0;
    rsp_valid   = '0;
    rsp_err     = 1'b0;
    alu_begin   = 1'b0;
    alu_abort   = 1'b0;
    alu_op_code = 2'b00;
    alu_inbus   = '0;

    // Watchdog first; progress and protocol decisions below override it.
    if (state_q == S_FEED || state_q == S_COLLECT || state_q == S_DRAIN) begin
      if (activity) begin
        wd_clr = 1'b1;
      end else if (wd_expire) begin
        state_d = S_ABORT;
      end else begin
        wd_inc = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Keep grant quiet while reset is held so no request is acknowledged.
        if (scan_hit && reset) begin
          do_grant        = 1'b1;
          grant[scan_sel] = 1'b1;
          state_d         = S_START;
        end
      end

      S_START: begin
        alu_begin   = 1'b1;
        alu_op_code = op_q;
        wd_clr      = 1'b1;
        state_d     = S_FEED;
      end

      S_FEED: begin
        alu_op_code = op_q;
        alu_inbus   = cur_word;
        if (alu_push) begin
          state_d = S_ABORT;
        end else if (alu_load) begin
          idx_inc = 1'b1;
          if (idx_q == last_word) begin
            state_d = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        alu_op_code = op_q;
        if (alu_push) begin
          cap_word = 1'b1;
          if (rcnt_q == last_res) begin
            state_d = alu_end ? S_DONE : S_DRAIN;
          end else if (alu_end) begin
            state_d = S_ABORT;
          end
        end else if (alu_end) begin
          state_d = S_ABORT;
        end
      end

      S_DRAIN: begin
        alu_op_code = op_q;
        if (alu_push) begin
          state_d = S_ABORT;
        end else if (alu_end) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        alu_op_code      = op_q;
        rsp_valid[sel_q] = 1'b1;
        ptr_adv          = 1'b1;
        state_d          = S_IDLE;
      end

      S_ABORT: begin
        alu_op_code      = op_q;
        rsp_valid[sel_q] = 1'b1;
        rsp_err          = 1'b1;
        alu_abort        = 1'b1;
        ptr_adv          = 1'b1;
        state_d          = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction context, counters, response words and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q  <= '0;
      sel_q  <= '0;
      op_q   <= 2'b00;
      opa_q  <= '0;
      opb_q  <= '0;
      opc_q  <= '0;
      idx_q  <= 2'd0;
      rcnt_q <= 2'd0;
      wdog_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (do_grant) begin
        sel_q  <= scan_sel;
        op_q   <= req_op[2*scan_sel +: 2];
        opa_q  <= req_opa[WIDTH*scan_sel +: WIDTH];
        opb_q  <= req_opb[WIDTH*scan_sel +: WIDTH];
        opc_q  <= req_opc[WIDTH*scan_sel +: WIDTH];
        hi_q   <= '0;
        lo_q   <= '0;
        idx_q  <= 2'd0;
        rcnt_q <= 2'd0;
      end

      if (state_q == S_START) begin
        idx_q <= 2'd0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 2'd1;
      end

      if (wd_clr) begin
        wdog_q <= '0;
      end else if (wd_inc) begin
        wdog_q <= wdog_q + 1'b1;
      end

      // mul returns A (high) then Q (low); div returns quotient then remainder.
      if (cap_word) begin
        rcnt_q <= rcnt_q + 2'd1;
        case (op_q)
          OP_MUL: begin
            if (rcnt_q == 2'd0) hi_q <= alu_outbus;
            else                lo_q <= alu_outbus;
          end
          OP_DIV: begin
            if (rcnt_q == 2'd0) lo_q <= alu_outbus;
            else                hi_q <= alu_outbus;
          end
          default: lo_q <= alu_outbus;
        endcase
      end

      if (ptr_adv) begin
        ptr_q <= (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter_sequencer.sv
module tb_alu_arbiter_sequencer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_opa, req_opb, req_opc;
  logic [N-1:0]   grant, rsp_valid;
  logic [W-1:0]   rsp_hi, rsp_lo;
  logic           rsp_err, alu_begin, alu_abort;
  logic [1:0]     alu_op_code;
  logic [W-1:0]   alu_inbus, alu_outbus;
  logic           alu_load, alu_push, alu_end;

  logic [1:0]   op_m [N];
  logic [W-1:0] a_m [N];
  logic [W-1:0] b_m [N];
  logic [W-1:0] c_m [N];

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  logic [N-1:0] last_grant;
  logic [N-1:0] rr_exp [5];

  alu_arbiter_sequencer #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op),
    .req_opa(req_opa), .req_opb(req_opb), .req_opc(req_opc),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_err(rsp_err), .alu_begin(alu_begin), .alu_op_code(alu_op_code),
    .alu_abort(alu_abort), .alu_inbus(alu_inbus), .alu_load(alu_load),
    .alu_push(alu_push), .alu_outbus(alu_outbus), .alu_end(alu_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-requester operands onto the flat request buses.
  always_comb begin
    req_op  = '0;
    req_opa = '0;
    req_opb = '0;
    req_opc = '0;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]  = op_m[i];
      req_opa[W*i +: W] = a_m[i];
      req_opb[W*i +: W] = b_m[i];
      req_opc[W*i +: W] = c_m[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge with all ALU strobes idle.
  task automatic step();
    @(posedge clk);
    #1;
    alu_load   = 1'b0;
    alu_push   = 1'b0;
    alu_end    = 1'b0;
    alu_outbus = '0;
  endtask

  // Round-robin model: first requesting index at or after the pointer.
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] word_of(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c, input int i);
    if (op == 2'b10) return (i == 0) ? b : a;
    if (op == 2'b11) return (i == 0) ? a : ((i == 1) ? b : c);
    return (i == 0) ? a : b;
  endfunction

  // Expected {hi, lo} from the requester's operands.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] c);
    logic [31:0] d;
    logic [W-1:0] s;
    case (op)
      2'b00: begin s = a + b; return {16'h0000, s}; end
      2'b01: begin s = a - b; return {16'h0000, s}; end
      2'b10: return 32'(a) * 32'(b);
      default: begin
        d = {a, b};
        return {16'(d % 32'(c)), 16'(d / 32'(c))};
      end
    endcase
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_m[i] = 2'($urandom_range(0, 3));
      a_m[i]  = 16'($urandom);
      b_m[i]  = 16'($urandom);
      c_m[i]  = 16'($urandom_range(1, 65535));
      if (op_m[i] == 2'b11) a_m[i] = 16'($urandom_range(0, int'(c_m[i]) - 1));
    end
  endtask

  // One full transaction with an emulated ALU; ends in the DONE cycle.
  task automatic txn(input logic [N-1:0] reqv, input bit hold, input int gap, input int drain);
    int s, nw, nr;
    logic [1:0]   op;
    logic [W-1:0] w [3];
    logic [W-1:0] ld [3];
    logic [W-1:0] res [2];
    logic [31:0]  p, expv;
    s  = pick(reqv);
    op = op_m[s];
    nw = (op == 2'b11) ? 3 : 2;
    nr = op[1] ? 2 : 1;
    for (int i = 0; i < 3; i++) begin
      w[i]  = word_of(op, a_m[s], b_m[s], c_m[s], i);
      ld[i] = '0;
    end
    res[0] = '0;
    res[1] = '0;
    p      = '0;
    expv   = ref_result(op, a_m[s], b_m[s], c_m[s]);

    step(); req = reqv;
    @(negedge clk);
    last_grant = grant;
    chk("grant", 32'(grant), 32'(1 << s));

    step(); req = hold ? reqv : (reqv & ~N'(1 << s));
    @(negedge clk);
    chk("begin", 32'(alu_begin), 1);
    chk("begin_op", 32'(alu_op_code), 32'(op));
    chk("grant_pulse", 32'(grant), 0);

    for (int i = 0; i < nw; i++) begin
      for (int g = 0; g < gap; g++) begin
        step();
        @(negedge clk);
        chk("inbus_hold", 32'(alu_inbus), 32'(w[i]));
      end
      step(); alu_load = 1'b1;
      @(negedge clk);
      chk("inbus", 32'(alu_inbus), 32'(w[i]));
      ld[i] = alu_inbus;
    end

    // Emulated ALU computes from the words it actually loaded.
    case (op)
      2'b00: res[0] = ld[0] + ld[1];
      2'b01: res[0] = ld[0] - ld[1];
      2'b10: begin p = 32'(ld[0]) * 32'(ld[1]); res[0] = p[31:16]; res[1] = p[15:0]; end
      default: begin
        p = {ld[0], ld[1]};
        if (ld[2] != '0) begin
          res[0] = 16'(p / 32'(ld[2]));
          res[1] = 16'(p % 32'(ld[2]));
        end
      end
    endcase

    for (int r = 0; r < nr; r++) begin
      for (int g = 0; g < gap; g++) begin
        step();
        @(negedge clk);
        chk("collect_wait", 32'(alu_abort), 0);
      end
      step();
      alu_push   = 1'b1;
      alu_outbus = res[r];
      alu_end    = (r == nr - 1) && (drain == 0);
      @(negedge clk);
      chk("inbus_idle", 32'(alu_inbus), 0);
    end

    if (drain > 0) begin
      for (int d = 1; d < drain; d++) begin
        step();
        @(negedge clk);
        chk("drain_wait", 32'(rsp_valid), 0);
      end
      step(); alu_end = 1'b1;
      @(negedge clk);
    end

    step();
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << s));
    chk("rsp_err", 32'(rsp_err), 0);
    chk("rsp_hi", 32'(rsp_hi), 32'(expv[31:16]));
    chk("rsp_lo", 32'(rsp_lo), 32'(expv[15:0]));
    chk("done_abort", 32'(alu_abort), 0);
    chk("done_no_grant", 32'(grant), 0);
    chk("done_op", 32'(alu_op_code), 32'(op));
    ptr_m = (s + 1) % N;
  endtask

  // Granted transaction that never receives a load.
  task automatic txn_timeout(input logic [N-1:0] reqv);
    int s;
    s = pick(reqv);
    step(); req = reqv;
    @(negedge clk);
    chk("to_grant", 32'(grant), 32'(1 << s));
    step(); req = '0;
    @(negedge clk);
    chk("to_begin", 32'(alu_begin), 1);
    for (int i = 0; i < TO; i++) begin
      step();
      @(negedge clk);
      chk("to_early", 32'({alu_abort, rsp_valid}), 0);
    end
    step();
    @(negedge clk);
    chk("to_abort", 32'(alu_abort), 1);
    chk("to_valid", 32'(rsp_valid), 32'(1 << s));
    chk("to_err", 32'(rsp_err), 1);
    chk("to_words", 32'({rsp_hi, rsp_lo}), 0);
    ptr_m = (s + 1) % N;
    step();
    @(negedge clk);
    chk("to_idle", 32'({alu_abort, rsp_valid, alu_op_code}), 0);
  endtask

  // Protocol violations: 0 push in FEED, 1 early end in COLLECT, 2 push in DRAIN.
  task automatic txn_err(input logic [N-1:0] reqv, input int mode);
    int s, nw;
    logic [1:0]   op;
    logic [W-1:0] ehi, elo;
    s   = pick(reqv);
    op  = op_m[s];
    nw  = (op == 2'b11) ? 3 : 2;
    ehi = '0;
    elo = '0;
    step(); req = reqv;
    @(negedge clk);
    chk("err_grant", 32'(grant), 32'(1 << s));
    step(); req = '0;
    @(negedge clk);
    if (mode == 0) begin
      step(); alu_load = 1'b1;
      step(); alu_push = 1'b1; alu_outbus = 16'hBEEF;
    end else begin
      for (int i = 0; i < nw; i++) begin
        step(); alu_load = 1'b1;
      end
      step();
      alu_push   = 1'b1;
      alu_outbus = 16'hC0DE;
      alu_end    = (mode == 1);
      if (op == 2'b10) ehi = 16'hC0DE;
      else             elo = 16'hC0DE;
      if (mode == 2) begin
        step(); alu_push = 1'b1; alu_outbus = 16'hD00D;
      end
    end
    step();
    @(negedge clk);
    chk("err_abort", 32'(alu_abort), 1);
    chk("err_valid", 32'(rsp_valid), 32'(1 << s));
    chk("err_err", 32'(rsp_err), 1);
    chk("err_hi", 32'(rsp_hi), 32'(ehi));
    chk("err_lo", 32'(rsp_lo), 32'(elo));
    ptr_m = (s + 1) % N;
    step();
    @(negedge clk);
    chk("err_idle", 32'({alu_abort, rsp_valid}), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    reset = 1'b0; req = 4'hF;
    alu_load = 1'b0; alu_push = 1'b0; alu_end = 1'b0; alu_outbus = '0;
    rand_ops();

    // Reset state with every requester asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_words", 32'({rsp_hi, rsp_lo}), 0);
    chk("rst_ctl", 32'({rsp_err, alu_begin, alu_abort, alu_op_code}), 0);
    chk("rst_inbus", 32'(alu_inbus), 0);
    step(); reset = 1'b1; req = '0;

    // Round robin with all requests held.
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      txn(4'hF, 1'b1, 0, 0);
      chk("rr_order", 32'(last_grant), 32'(rr_exp[i]));
    end

    // Directed add.
    op_m[1] = 2'b00; a_m[1] = 16'h0005; b_m[1] = 16'h0003;
    txn(4'b0010, 1'b0, 0, 0);
    chk("add_lo", 32'(rsp_lo), 32'h0008);
    chk("add_hi", 32'(rsp_hi), 0);

    // Directed div through DRAIN.
    op_m[0] = 2'b11; a_m[0] = 16'h0000; b_m[0] = 16'h0064; c_m[0] = 16'h0007;
    txn(4'b0001, 1'b0, 0, 2);
    chk("div_lo", 32'(rsp_lo), 32'h000E);
    chk("div_hi", 32'(rsp_hi), 32'h0002);

    // Directed mul with idle gaps between strobes.
    op_m[2] = 2'b10; a_m[2] = 16'h0010; b_m[2] = 16'h0020;
    txn(4'b0100, 1'b0, 3, 1);
    chk("mul_hi", 32'(rsp_hi), 32'h0000);
    chk("mul_lo", 32'(rsp_lo), 32'h0200);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      rand_ops();
      txn(N'($urandom_range(1, 15)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Watchdog and protocol aborts.
    rand_ops();
    txn_timeout(N'($urandom_range(1, 15)));
    txn_err(4'b0001, 0);
    op_m[3] = 2'b10;
    txn_err(4'b1000, 1);
    op_m[1] = 2'b11;
    txn_err(4'b0010, 1);
    op_m[2] = 2'b01;
    txn_err(4'b0100, 2);

    // Put the pointer at 3, then reset in the middle of a mul.
    rand_ops();
    txn(4'b0100, 1'b0, 0, 0);
    op_m[1] = 2'b10; a_m[1] = 16'h0011; b_m[1] = 16'h0022;
    step(); req = 4'b0010;
    @(negedge clk);
    chk("mid_grant", 32'(grant), 32'h2);
    step(); req = '0;
    step(); alu_load = 1'b1;
    step(); alu_load = 1'b1;
    step(); alu_push = 1'b1; alu_outbus = 16'h1234;
    step(); reset = 1'b0;
    @(negedge clk);
    chk("mid_hi_before", 32'(rsp_hi), 32'h1234);
    step(); reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_words", 32'({rsp_hi, rsp_lo}), 0);
    chk("mid_rst_ctl", 32'({rsp_err, alu_begin, alu_abort, alu_op_code}), 0);
    chk("mid_rst_inbus", 32'(alu_inbus), 0);
    ptr_m = 0;
    rand_ops();
    txn(4'b1100, 1'b0, 0, 0);
    chk("post_rst_grant", 32'(last_grant), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_sequencer.md
Name: alu_arbiter_sequencer

Overview:
- Shares one Paul-ALU (one-hot control unit plus datapath) between N_REQ requesters, selected round-robin.
- For the granted requester it starts the ALU with BEGIN and op_code, then feeds operand words onto INBUS one per ALU load strobe.
- It collects result words from OUTBUS, waits for END, then returns a single response; a watchdog aborts hung or protocol-violating transactions.
- Sits between the requester fabric and the ALU top level.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 16, ALU data word width
TIMEOUT, 255, idle cycles without ALU activity before abort (counter width = clog2(TIMEOUT+1))

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
req  input  N_REQ  per-requester request level; held until grant
req_op  input  2*N_REQ  op_code per requester (slice i = [2i+1:2i]): 00 add, 01 sub, 10 mul, 11 div
req_opa  input  WIDTH*N_REQ  operand A (add/sub left operand, mul multiplicand, div dividend high)
req_opb  input  WIDTH*N_REQ  operand B (add/sub right operand, mul multiplier, div dividend low)
req_opc  input  WIDTH*N_REQ  operand C (div divisor; ignored otherwise)
grant  output  N_REQ  one-hot, one-cycle pulse; operands sampled this cycle
rsp_valid  output  N_REQ  one-hot, one-cycle response pulse to the owner
rsp_hi  output  WIDTH  result high word / remainder
rsp_lo  output  WIDTH  result low word / quotient / sum
rsp_err  output  1  qualifies rsp_valid: transaction aborted
alu_begin  output  1  BEGIN to the control unit, one-cycle pulse
alu_op_code  output  2  op_code to the ALU, stable for the whole transaction
alu_abort  output  1  one-cycle pulse forcing the ALU back to IDLE
alu_inbus  output  WIDTH  operand word currently offered
alu_load  input  1  ALU sampled alu_inbus this cycle
alu_push  input  1  alu_outbus valid this cycle
alu_outbus  input  WIDTH  ALU result word
alu_end  input  1  END from the control unit

Behaviour:
- Reset (reset==0 at an edge) has priority over everything, including mid-transaction.
- On reset: all outputs 0; state IDLE; round-robin pointer = 0; response registers cleared. The ALU is assumed reset by the same signal, so no alu_abort is issued.
- FSM states: IDLE, START, FEED, COLLECT, DRAIN, DONE, ABORT.
- IDLE: if any req bit is set, select the first set bit scanning upward from pointer, with wrap-around.
  - Same cycle: pulse grant[sel]; latch sel, op, opa, opb, opc; clear rsp_hi and rsp_lo; go to START.
  - No request: stay in IDLE.
- START: alu_begin=1 for exactly this cycle; alu_op_code=latched op, held until the state after DONE/ABORT; word index=0; go to FEED.
- FEED: alu_inbus = operand word[index].
  - Word order: add/sub A,B (2 words); mul B,A (Q then M, 2 words); div A,B,C (3 words).
  - Each alu_load increments index.
  - On the alu_load that consumes the last word, go to COLLECT.
  - alu_inbus is 0 outside FEED.
- COLLECT: each alu_push captures alu_outbus.
  - add/sub: 1 word -> rsp_lo.
  - mul: 2 words; first (A) -> rsp_hi, second (Q) -> rsp_lo.
  - div: 2 words; first (Q) -> rsp_lo, second (A) -> rsp_hi.
  - After the expected count, go to DRAIN.
  - If alu_end arrives in the same cycle as the final push, go directly to DONE.
- DRAIN: wait for alu_end, then go to DONE.
- DONE: pulse rsp_valid[sel] with rsp_err=0; pointer = sel+1 mod N_REQ; go to IDLE. No grant is issued in DONE.
- Watchdog counter:
  - Cleared in START and on any cycle with alu_load or alu_push.
  - Otherwise increments in FEED, COLLECT and DRAIN.
  - Reaching TIMEOUT goes to ABORT.
- Protocol errors, each goes to ABORT:
  - alu_push during FEED.
  - alu_end before COLLECT has its full count.
  - alu_push during DRAIN.
- ABORT (one cycle): pulse alu_abort and rsp_valid[sel] with rsp_err=1; rsp_hi/rsp_lo hold any words captured so far; pointer advances as in DONE; next state IDLE.
- alu_load outside FEED and alu_end outside COLLECT/DRAIN are ignored.
- req bits deasserting after grant have no effect; the transaction completes.
- Minimum latency, grant to rsp_valid: 1 (START) + one cycle per operand word + one cycle per result word + 1 (DONE), given back-to-back ALU strobes.

Test Plan:
- Add: req[1], op 00, A=0x0005, B=0x0003; ALU loads 2 words then pushes 0x0008 with alu_end -> grant=0010 for one cycle; alu_begin one cycle later; rsp_valid=0010, rsp_lo=0x0008, rsp_hi=0, rsp_err=0.
- Div: req[0], A=0x0000, B=0x0064, C=0x0007 -> inbus order 0x0000, 0x0064, 0x0007; pushes 0x000E then 0x0002 -> rsp_lo=0x000E, rsp_hi=0x0002.
- Mul with gaps: A=0x0010, B=0x0020; inbus order 0x0020 then 0x0010; 3 idle cycles between strobes; pushes 0x0000 then 0x0200 -> rsp_hi=0x0000, rsp_lo=0x0200, no abort.
- Round-robin: req=1111 held constantly -> grants in order 0001, 0010, 0100, 1000, 0001; no requester granted twice before the others.
- Timeout: TIMEOUT=8; no alu_load after alu_begin -> exactly 8 cycles into FEED, alu_abort pulse, rsp_valid[sel]=1 with rsp_err=1, then IDLE.
- Reset mid-transaction: reset low during COLLECT of a mul -> next cycle all outputs 0 and state IDLE; after release, req[2] alone is granted first (pointer=0, so scan 0,1,2).
